// File: rtl/dp_seq_pkg.sv
// Shared types and encodings for the dp_sequencer datapath controller:
// FSM states, opcode/op values, ALU and shifter codes, instruction field positions.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_IMM,
    S_WR_REG,
    S_DONE
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_MSB  = 10;
  localparam int RN_LSB  = 8;
  localparam int RD_MSB  = 7;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_MSB  = 2;
  localparam int RM_LSB  = 0;

endpackage

// File: rtl/dp_seq_decode.sv
// Combinational instruction classifier: splits the latched instruction into
// its class (mov_imm, mov_reg, alu, cmp, mvn, illegal) and register/shift fields.
module dp_seq_decode
  import dp_seq_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic        o_mov_imm,
  output logic        o_mov_reg,
  output logic        o_alu,
  output logic        o_cmp,
  output logic        o_mvn,
  output logic        o_illegal,
  output logic [1:0]  o_op,
  output logic [1:0]  o_sh,
  output logic [2:0]  o_rn,
  output logic [2:0]  o_rd,
  output logic [2:0]  o_rm
);

  logic [2:0] w_opc;
  logic [1:0] w_op;
  logic       w_is_mov;
  logic       w_is_alu;

  assign w_opc = i_instr[OPC_MSB:OPC_LSB];
  assign w_op  = i_instr[OP_MSB:OP_LSB];

  assign o_op = w_op;
  assign o_sh = i_instr[SH_MSB:SH_LSB];
  assign o_rn = i_instr[RN_MSB:RN_LSB];
  assign o_rd = i_instr[RD_MSB:RD_LSB];
  assign o_rm = i_instr[RM_MSB:RM_LSB];

  // "alu" covers the two-operand ops that write Rd (ADD and AND)
  always_comb begin
    w_is_mov  = (w_opc == OPC_MOV);
    w_is_alu  = (w_opc == OPC_ALU);
    o_mov_imm = w_is_mov && (w_op == OP_MOV_IMM);
    o_mov_reg = w_is_mov && (w_op == OP_MOV_REG);
    o_alu     = w_is_alu && ((w_op == OP_ADD) || (w_op == OP_AND));
    o_cmp     = w_is_alu && (w_op == OP_CMP);
    o_mvn     = w_is_alu && (w_op == OP_MVN);
    o_illegal = !(o_mov_imm || o_mov_reg || o_alu || o_cmp || o_mvn);
  end

endmodule

// File: rtl/dp_sequencer.sv
// Multicycle controller running one instruction per start on the regfile/shifter/ALU datapath.
// Optional macro DPSEQ_RETIRE_CNT_EN adds the retired-instruction counter port.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int IMM_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] instr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              vsel,
  output logic              loada,
  output logic              loadb,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic              loadc,
  output logic              loads,
`ifdef DPSEQ_RETIRE_CNT_EN
  output logic [15:0]       retired,
`endif
  output logic [DATA_W-1:0] datapath_in
);

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_instr;
  logic              r_err;

  logic       w_mov_imm, w_mov_reg, w_alu, w_cmp, w_mvn, w_illegal;
  logic [1:0] w_op, w_sh;
  logic [2:0] w_rn, w_rd, w_rm;

  dp_seq_decode u_decode (
    .i_instr   (r_instr),
    .o_mov_imm (w_mov_imm),
    .o_mov_reg (w_mov_reg),
    .o_alu     (w_alu),
    .o_cmp     (w_cmp),
    .o_mvn     (w_mvn),
    .o_illegal (w_illegal),
    .o_op      (w_op),
    .o_sh      (w_sh),
    .o_rn      (w_rn),
    .o_rd      (w_rd),
    .o_rm      (w_rm)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // err is sticky across the DONE of an illegal instruction and clears only on the next accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_instr <= instr;
      r_err   <= 1'b0;
    end else if (r_state == S_DECODE && w_illegal) begin
      r_err   <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_DECODE;
      S_DECODE: begin
        if (w_mov_imm)               w_next = S_WR_IMM;
        else if (w_mov_reg || w_mvn) w_next = S_GET_B;
        else if (w_alu || w_cmp)     w_next = S_GET_A;
        else                         w_next = S_DONE;
      end
      S_GET_A:  w_next = S_GET_B;
      S_GET_B:  w_next = S_EXEC;
      S_EXEC:   w_next = w_cmp ? S_DONE : S_WR_REG;
      S_WR_IMM: w_next = S_DONE;
      S_WR_REG: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    loadc    = 1'b0;
    loads    = 1'b0;
    done     = 1'b0;
    unique case (r_state)
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      // MOV reg and MVN pass B through the ALU with A forced to zero
      S_EXEC: begin
        shift = w_sh;
        asel  = w_mov_reg || w_mvn;
        ALUop = w_mov_reg ? ALU_ADD : w_op;
        loadc = !w_cmp;
        loads = w_cmp;
      end
      S_WR_REG: begin
        writenum = w_rd;
        write    = 1'b1;
      end
      S_WR_IMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign datapath_in = {{(DATA_W-IMM_W){r_instr[IMM_W-1]}}, r_instr[IMM_W-1:0]};

`ifdef DPSEQ_RETIRE_CNT_EN
  logic [15:0] r_retired;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    r_retired <= '0;
    else if (r_state == S_DONE && !r_err) r_retired <= r_retired + 16'd1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: doc/dp_sequencer.md
Name: dp_sequencer

Overview:
Multicycle controller that executes one 16-bit instruction per start request on the register-file/shifter/ALU datapath.
- Latches and decodes the instruction.
- Sequences readnum/loada/loadb/loadc/loads/write and the mux selects state by state.
- Replaces the switch-driven manual control path; the datapath itself is unchanged.
- Pulses done when the instruction retires.

Parameters:
IMM_W, 8, width of immediate field, sign-extended to 16 bits on datapath_in
DATA_W, 16, instruction and datapath_in width; fixed at 16

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
instr  input  16  instruction, captured on the cycle start is accepted
busy  output  1  high from the cycle after acceptance until DONE inclusive
done  output  1  one-cycle pulse in DONE
err  output  1  set on illegal instruction; cleared on next accepted start
readnum  output  3  register-file read address
writenum  output  3  register-file write address
write  output  1  register-file write enable
vsel  output  1  1 = write datapath_in, 0 = write C
loada  output  1  load A register
loadb  output  1  load B register
asel  output  1  1 = force ALU A input to 0
bsel  output  1  1 = ALU B input from datapath_in
shift  output  2  shifter op
ALUop  output  2  00 add, 01 sub, 10 and, 11 not B
loadc  output  1  load C register
loads  output  1  load status register
datapath_in  output  16  sign-extended imm8 of latched instr

Behaviour:
- Reset (async, reset_n=0): state IDLE, instruction register 0, err 0. All outputs 0, including datapath_in. Reset mid-instruction aborts immediately; a write in progress is dropped on that edge.
- Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
- Legal instructions:
  - 110/10: MOV Rn,#imm
  - 110/00: MOV Rd,Rm{,sh}
  - 101/00: ADD Rd,Rn,Rm{,sh}
  - 101/01: CMP Rn,Rm{,sh}
  - 101/10: AND Rd,Rn,Rm{,sh}
  - 101/11: MVN Rd,Rm{,sh}
  - Anything else is illegal.
- States: IDLE, DECODE, GET_A, GET_B, EXEC, WR_IMM, WR_REG, DONE.
- IDLE: when start=1, latch instr and go to DECODE. Otherwise stay.
- DECODE paths:
  - MOV imm → WR_IMM
  - MOV reg, MVN → GET_B
  - ADD/CMP/AND → GET_A
  - illegal → DONE with err set
- GET_A: readnum=Rn, loada=1 → GET_B.
- GET_B: readnum=Rm, loadb=1 → EXEC.
- EXEC: shift=sh, bsel=0.
  - asel=1 for MOV reg and MVN, else 0.
  - ALUop=op for opcode 101, else 00.
  - loadc=1 except CMP; loads=1 only for CMP.
  - Next state: CMP → DONE, else → WR_REG.
- WR_REG: writenum=Rd, vsel=0, write=1 → DONE.
- WR_IMM: writenum=Rn, vsel=1, write=1 → DONE.
- DONE: done=1 → IDLE.
- Outputs are Moore, decoded from state plus latched instr. Every control not listed for a state is 0; readnum and writenum are 0 when unused.
- datapath_in = {{8{imm8[7]}},imm8}, driven continuously from the latched instr.
- Latency, counted as cycles from the accepting edge to done high:
  - MOV imm 3
  - illegal 2
  - MOV reg / MVN 5
  - CMP 5
  - ADD / AND 6
- start during busy is ignored and not queued. start held high in DONE is not accepted until IDLE, so back-to-back instructions have a minimum gap of 1 cycle.

Optional Feature:
DPSEQ_RETIRE_CNT_EN
- Defined: adds output port retired[15:0]. Increments on every DONE cycle without err, wraps 0xFFFF→0, resets to 0.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package dp_seq_pkg holds:
  - state enum
  - opcode/op constants (OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD/CMP/AND/MVN)
  - ALUop and shift encodings
  - instruction-field bit-position constants
- Sub-module dp_seq_decode: combinational, latched instr → instruction class (mov_imm, mov_reg, alu, cmp, mvn, illegal) plus fields.
- FSM and output decode stay in dp_sequencer.

Test Plan:
- Reset with start=1 and instr=0xD007, then release → all outputs 0, no accept while reset_n=0; after release, accept next cycle.
- instr=0xD007 (MOV R0,#7) → WR_IMM with writenum=0, vsel=1, write=1, datapath_in=0x0007; done 3 cycles after accept.
- instr=0xD5FE (MOV R5,#-2) → writenum=5, datapath_in=0xFFFE.
- instr=0xA140 (ADD R2,R1,R0), checked per state:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - EXEC: ALUop=00, loadc=1
  - WR_REG: writenum=2, write=1
  - done at cycle 6
- instr=0xA900 (CMP R1,R0) → EXEC has ALUop=01, loads=1, loadc=0; write never asserted; done at cycle 5.
- instr=0xC069 (MOV R3,R1,LSL#1) → no loada; EXEC has shift=01, asel=1; writenum=3. Then instr=0x0000 → err=1, done at cycle 2. Next legal start clears err. start pulses while busy are ignored.
